// File: rtl/conway_sequencer_if.sv
// Run-control bus between the life-core controller (master) and the
// conway_sequencer (slave). The master issues requests and returns the
// core's current/next state; the sequencer drives the core controls and status.
interface conway_sequencer_if #(
   parameter int GEN_W = 16
);
   logic             load_req;
   logic             run_req;
   logic             step_req;
   logic             stop_req;
   logic [GEN_W-1:0] gen_limit;
   logic [63:0]      cur_state;
   logic [63:0]      next_state;
   logic             core_clk_en;
   logic             core_load_run;
   logic [GEN_W-1:0] gen_count;
   logic             busy;
   logic             done;
   logic [2:0]       halt_reason;

   modport master (
      output load_req, run_req, step_req, stop_req, gen_limit, cur_state, next_state,
      input  core_clk_en, core_load_run, gen_count, busy, done, halt_reason
   );

   modport slave (
      input  load_req, run_req, step_req, stop_req, gen_limit, cur_state, next_state,
      output core_clk_en, core_load_run, gen_count, busy, done, halt_reason
   );
endinterface

// File: rtl/conway_sequencer.sv
// Run-control FSM for the 8x8 life core: load, single-step and prescaled
// free-run, with automatic halt on extinction, still life or generation limit.
// Optional oscillator (period-2) detection is enabled by defining the macro
// CONWAY_OSC_DETECT_EN; the default build omits it and never reports code 4.
module conway_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int GEN_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   conway_sequencer_if.slave  bus
);
   localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_RUN,
      S_HALT
   } state_t;

   state_t           state_reg;
   logic [PS_W-1:0]  prescale_reg;
   logic             clk_en_reg;
   logic             load_run_reg;
   logic [GEN_W-1:0] gen_count_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [2:0]       halt_reason_reg;
`ifdef CONWAY_OSC_DETECT_EN
   logic [63:0]      prev_state_reg;
`endif

   logic [GEN_W-1:0] eff_limit;
   logic [2:0]       halt_code;
   logic             advancing;
   logic             loading;

   // The enable cycle now ending either loads the core or advances it.
   assign advancing = clk_en_reg && load_run_reg;
   assign loading   = clk_en_reg && !load_run_reg;

   // Halt conditions in priority order; 0 means the core may advance.
   always_comb begin
      eff_limit = (bus.gen_limit == '0) ? '1 : bus.gen_limit;
      halt_code = 3'd0;
      if (bus.cur_state == 64'd0)
         halt_code = 3'd2;
      else if (bus.next_state == bus.cur_state)
         halt_code = 3'd1;
`ifdef CONWAY_OSC_DETECT_EN
      else if (gen_count_reg != '0 && bus.next_state == prev_state_reg)
         halt_code = 3'd4;
`endif
      else if (gen_count_reg == eff_limit)
         halt_code = 3'd3;
   end

`ifdef CONWAY_OSC_DETECT_EN
   // Remember the generation before each advance so a period-2 cycle shows
   // up as next_state matching it.
   always_ff @(posedge clk) begin
      if (reset || loading)
         prev_state_reg <= 64'd0;
      else if (advancing)
         prev_state_reg <= bus.cur_state;
   end
`endif

   // Main sequencer: state, prescaler, generation counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         prescale_reg    <= '0;
         clk_en_reg      <= 1'b0;
         load_run_reg    <= 1'b1;
         gen_count_reg   <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         halt_reason_reg <= 3'd0;
      end else begin
         // Enable and done are single-cycle unless a branch below re-arms them.
         clk_en_reg   <= 1'b0;
         load_run_reg <= 1'b1;
         done_reg     <= 1'b0;

         // Counter tracks what the core actually did this cycle.
         if (loading)
            gen_count_reg <= '0;
         else if (advancing)
            gen_count_reg <= gen_count_reg + GEN_W'(1);

         case (state_reg)
            S_IDLE: begin
               prescale_reg <= '0;
               if (bus.load_req) begin
                  state_reg       <= S_LOAD;
                  clk_en_reg      <= 1'b1;
                  load_run_reg    <= 1'b0;
                  busy_reg        <= 1'b1;
                  halt_reason_reg <= 3'd0;
               end else if (bus.step_req) begin
                  if (halt_code != 3'd0) begin
                     state_reg       <= S_HALT;
                     done_reg        <= 1'b1;
                     halt_reason_reg <= halt_code;
                  end else begin
                     state_reg  <= S_STEP;
                     clk_en_reg <= 1'b1;
                     busy_reg   <= 1'b1;
                  end
               end else if (bus.run_req) begin
                  state_reg <= S_RUN;
                  busy_reg  <= 1'b1;
               end
            end

            S_LOAD: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end

            S_STEP: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end

            S_RUN: begin
               if (bus.stop_req) begin
                  // Stop beats a coincident decision: no advance is issued.
                  state_reg    <= S_IDLE;
                  busy_reg     <= 1'b0;
                  prescale_reg <= '0;
               end else if (prescale_reg == PS_LAST) begin
                  prescale_reg <= '0;
                  if (halt_code != 3'd0) begin
                     state_reg       <= S_HALT;
                     busy_reg        <= 1'b0;
                     done_reg        <= 1'b1;
                     halt_reason_reg <= halt_code;
                  end else begin
                     clk_en_reg <= 1'b1;
                  end
               end else begin
                  prescale_reg <= prescale_reg + PS_W'(1);
               end
            end

            S_HALT: begin
               if (bus.load_req) begin
                  state_reg       <= S_LOAD;
                  clk_en_reg      <= 1'b1;
                  load_run_reg    <= 1'b0;
                  busy_reg        <= 1'b1;
                  halt_reason_reg <= 3'd0;
               end else if (bus.stop_req) begin
                  state_reg       <= S_IDLE;
                  halt_reason_reg <= 3'd0;
               end
            end

            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.core_clk_en   = clk_en_reg;
   assign bus.core_load_run = load_run_reg;
   assign bus.gen_count     = gen_count_reg;
   assign bus.busy          = busy_reg;
   assign bus.done          = done_reg;
   assign bus.halt_reason   = halt_reason_reg;
endmodule

// File: doc/conway_sequencer.md
Name:
conway_sequencer

Overview:
- Run-control FSM for the 8x8 life core. Drives the core's clock-enable and load/run select.
- Counts generations and paces advances with a prescaler.
- Supports single-step.
- Halts automatically on extinction, still life or a generation limit, reporting the reason.

Parameters:
TICK_DIV, 4, clk cycles per generation in RUN; legal range is >=2
GEN_W, 16, width of the generation counter and limit

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load_req  input  1  request to load the core from its initial-state input
run_req  input  1  request to start free-running
step_req  input  1  request to advance exactly one generation
stop_req  input  1  request to abort RUN, or clear HALT
gen_limit  input  GEN_W  halt after this many generations; 0 means 2^GEN_W-1
cur_state  input  64  core's current-state output
next_state  input  64  core's next-state output
core_clk_en  output  1  to core clock gate
core_load_run  output  1  to core select; 0 = load, 1 = run
gen_count  output  GEN_W  generations advanced since last load
busy  output  1  high in LOAD, STEP and RUN
done  output  1  one-cycle pulse on entry to HALT
halt_reason  output  3  0 none, 1 still, 2 extinct, 3 limit, 4 oscillator

Behaviour:
- All outputs registered.
- Reset values: state IDLE, core_clk_en=0, core_load_run=1, gen_count=0, busy=0, done=0, halt_reason=0, prescaler=0.
- Reset mid-operation returns to these values on the next edge. Core memory is not cleared.
- States: IDLE, LOAD, STEP, RUN, HALT.
- IDLE:
  - Request priority is load > step > run. stop_req is ignored.
  - load_req -> LOAD.
  - step_req -> STEP.
  - run_req -> RUN with prescaler=0.
- LOAD (1 cycle):
  - core_load_run=0, core_clk_en=1. The core captures the initial state at the end of the cycle.
  - gen_count cleared at that same edge.
  - halt_reason cleared.
  - Then -> IDLE.
- STEP (1 cycle):
  - Halt checks run on entry, using values from the requesting cycle.
  - If no halt condition: core_clk_en=1, core_load_run=1, gen_count+1, then -> IDLE.
  - If a halt condition holds: no enable, -> HALT.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - Decision cycle is prescaler==TICK_DIV-1.
  - On the decision cycle, evaluate halt checks.
  - If none hold: core_clk_en=1 on the following cycle, and gen_count+1 at the end of that enable cycle.
  - core_clk_en is otherwise 0. Enable never pulses in two consecutive cycles.
- Halt checks, in priority order:
  1. cur_state==0 -> extinct (2).
  2. next_state==cur_state -> still (1).
  3. gen_count==effective limit -> limit (3).
- On a halt: go to HALT. done=1 for the entry cycle. halt_reason holds until HALT is left.
- HALT:
  - core_clk_en=0.
  - load_req -> LOAD.
  - stop_req -> IDLE with halt_reason=0.
  - run_req and step_req are ignored.
- stop_req in RUN -> IDLE next cycle, prescaler cleared.
- stop_req coinciding with a decision cycle: stop wins, no advance.
- load_req, run_req and step_req are ignored while in RUN, LOAD or STEP.
- gen_count never exceeds the effective limit, so it never wraps.
- TICK_DIV>=2 guarantees each decision sees the post-advance state.

Optional Feature:
- Macro: CONWAY_OSC_DETECT_EN.
- Defined:
  - Adds a 64-bit prev_state register, loaded with cur_state at each enable cycle and cleared on LOAD.
  - Adds check 4, placed after check 2 and before check 3: gen_count>=1 and next_state==prev_state -> oscillator (4).
- Undefined:
  - No prev_state register.
  - Code 4 is never produced.

Test Plan:
1. Reset then idle 10 cycles -> core_clk_en=0, core_load_run=1, gen_count=0, busy=0, halt_reason=0.
2. Initial state 64'h0303 (block), load_req, then run_req, TICK_DIV=4 -> halt at the first decision; gen_count=0, halt_reason=1, done pulses once.
3. Initial state 64'h1, load, run -> one advance; gen_count=1, cur_state=0, halt_reason=2.
4. Blinker 64'h0E00, gen_limit=5, macro off -> gen_count=5, halt_reason=3, cur_state=64'h040404, exactly 5 enable pulses spaced 4 cycles apart.
5. Same stimulus with CONWAY_OSC_DETECT_EN -> gen_count=1, halt_reason=4, cur_state=64'h040404.
6. Blinker, step_req x3 then run_req, with stop_req asserted on a decision cycle -> gen_count=3 after the steps, no advance on the stop cycle, IDLE next cycle.
